// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hazard_pkg;

  // Forward-select code for "take the operand from the register file".
  localparam int FW_RF = 0;

  // Tuse value meaning the operand is not read by the instruction.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Multiply/divide unit occupancy states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // Forward-select code for producer stage i (0 = E, 1 = M, ...).
  function automatic int fw_stg(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/hazard_unit_n_mdu_busy_ctr.sv
// Multi-cycle MDU occupancy tracker: IDLE/BUSY FSM with a 4-bit down-counter.
// Latency: busy rises one cycle after an accepted start, stays high for MUL_LAT or DIV_LAT cycles.
// Backpressure: a start while BUSY is ignored; cancel suppresses a start only, never aborts a running op.
module mdu_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic cancel,
  output logic busy
);

  localparam logic [3:0] C_MUL_LOAD = 4'(MUL_LAT - 1);
  localparam logic [3:0] C_DIV_LOAD = 4'(DIV_LAT - 1);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  // State and counter registers; reset may land mid-operation and returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: load latency on an uncancelled start, count down while busy.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (start && !cancel) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = div ? C_DIV_LOAD : C_MUL_LOAD;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign busy = (r_state == BUSY);

endmodule

// File: rtl/hazard_unit_n.sv
// Hazard/bypass controller for an N-producer MIPS pipeline (optional perf counters: HAZARD_PERF_EN).
// Latency: forward selects, stalls and flushes are combinational; mdu_busy rises one cycle after start.
// Backpressure: stall_pc/stall_f_d hold the front end on data or MDU hazards; exception/ERET override stalls.
module hazard_unit_n
  import hazard_pkg::*;
#(
  parameter int NSTG    = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int FSW     = $clog2(NSTG + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [1:0]        tuse_rs_d,
  input  logic [1:0]        tuse_rt_d,
  input  logic [4:0]        rs_e,
  input  logic [4:0]        rt_e,
  input  logic [5*NSTG-1:0] prod_addr,
  input  logic [NSTG-1:0]   prod_we,
  input  logic [2*NSTG-1:0] prod_tnew,
  input  logic              mdu_start_e,
  input  logic              mdu_div_e,
  input  logic              mdu_use_d,
  input  logic              likely_d,
  input  logic              branch_taken_d,
  input  logic              exc_m,
  input  logic              eret_m,
  output logic [FSW-1:0]    fwd_rs_d,
  output logic [FSW-1:0]    fwd_rt_d,
  output logic [FSW-1:0]    fwd_rs_e,
  output logic [FSW-1:0]    fwd_rt_e,
  output logic              stall_pc,
  output logic              stall_f_d,
  output logic              flush_f_d,
  output logic              flush_d_e,
  output logic              flush_e_m,
  output logic              flush_m_w,
  output logic              pc_exc,
  output logic              pc_eret,
  output logic              mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_data_stall,
  output logic [31:0]       perf_mdu_stall,
  output logic [31:0]       perf_flush
`endif
);

  // Nearest producer at index >= 1 wins; E (index 0) has no result to bypass yet.
  function automatic logic [FSW-1:0] fwd_sel(
    input logic [4:0]        src,
    input logic [5*NSTG-1:0] addr,
    input logic [NSTG-1:0]   we
  );
    logic [FSW-1:0] sel;
    sel = FSW'(FW_RF);
    for (int i = NSTG - 1; i >= 1; i--) begin
      if (we[i] && (addr[5*i +: 5] == src) && (src != 5'd0)) begin
        sel = FSW'(fw_stg(i));
      end
    end
    return sel;
  endfunction

  // Only the nearest matching producer decides; its Tnew is compared to the consumer's Tuse.
  function automatic logic src_stall(
    input logic [4:0]        src,
    input logic [1:0]        tuse,
    input logic [5*NSTG-1:0] addr,
    input logic [NSTG-1:0]   we,
    input logic [2*NSTG-1:0] tnew
  );
    logic       hit;
    logic [1:0] t;
    hit = 1'b0;
    t   = 2'd0;
    for (int j = NSTG - 1; j >= 0; j--) begin
      if (we[j] && (addr[5*j +: 5] == src)) begin
        hit = 1'b1;
        t   = tnew[2*j +: 2];
      end
    end
    return hit && (src != 5'd0) && (tuse != TUSE_NONE) && (t > tuse);
  endfunction

  logic w_data_stall;
  logic w_mdu_stall;
  logic w_stall;
  logic w_mdu_busy;
  logic w_cancel;

  // Forward selects for the four consumers.
  always_comb begin
    fwd_rs_d = fwd_sel(rs_d, prod_addr, prod_we);
    fwd_rt_d = fwd_sel(rt_d, prod_addr, prod_we);
    fwd_rs_e = fwd_sel(rs_e, prod_addr, prod_we);
    fwd_rt_e = fwd_sel(rt_e, prod_addr, prod_we);
  end

  // Tuse/Tnew data-hazard arbitration for both D-stage sources.
  always_comb begin
    w_data_stall = src_stall(rs_d, tuse_rs_d, prod_addr, prod_we, prod_tnew) ||
                   src_stall(rt_d, tuse_rt_d, prod_addr, prod_we, prod_tnew);
  end

  // An exception or ERET in M kills the op in E, so it must not occupy the MDU.
  assign w_cancel = exc_m || eret_m;

  mdu_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start_e),
    .div    (mdu_div_e),
    .cancel (w_cancel),
    .busy   (w_mdu_busy)
  );

  assign mdu_busy    = w_mdu_busy;
  assign w_mdu_stall = mdu_use_d && (w_mdu_busy || mdu_start_e);
  assign w_stall     = w_data_stall || w_mdu_stall;

  // Exception beats ERET; both beat stalls so the redirect is never held off.
  assign stall_pc  = w_stall && !exc_m && !eret_m;
  assign stall_f_d = w_stall && !exc_m && !eret_m;
  assign flush_d_e = w_stall || exc_m || eret_m;
  assign flush_f_d = exc_m || eret_m || (likely_d && !branch_taken_d && !w_stall);
  assign flush_e_m = exc_m;
  assign flush_m_w = exc_m;
  assign pc_exc    = exc_m;
  assign pc_eret   = eret_m && !exc_m;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_data_stall;
  logic [31:0] r_perf_mdu_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters: hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_data_stall <= 32'd0;
      r_perf_mdu_stall  <= 32'd0;
      r_perf_flush      <= 32'd0;
    end else begin
      if (w_data_stall && (r_perf_data_stall != 32'hFFFF_FFFF)) begin
        r_perf_data_stall <= r_perf_data_stall + 32'd1;
      end
      if (w_mdu_stall && (r_perf_mdu_stall != 32'hFFFF_FFFF)) begin
        r_perf_mdu_stall <= r_perf_mdu_stall + 32'd1;
      end
      if (flush_f_d && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_data_stall = r_perf_data_stall;
  assign perf_mdu_stall  = r_perf_mdu_stall;
  assign perf_flush      = r_perf_flush;
`endif

endmodule
